// File: rtl/riscv_isa_pkg.sv
// Shared ISA constants for the instruction-path tools.
// Holds the instruction format codes, the base opcodes and the writer FSM states.
package riscv_isa_pkg;

    localparam logic [1:0] FMT_I       = 2'b00;
    localparam logic [1:0] FMT_S       = 2'b01;
    localparam logic [1:0] FMT_ILLEGAL = 2'b10;
    localparam logic [1:0] FMT_SB      = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FULL = 2'b10
    } wr_state_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: builds an I/S/SB instruction word and flags format legality and immediate range.
// Define INSTR_ASM_RANGE_CHECK_EN to reject immediates outside the signed 12-bit range.
module imm_pack
    import riscv_isa_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [63:0] imm_i,
    output logic [31:0] word_o,
    output logic        fmt_ok_o,
    output logic        range_ok_o
);

`ifdef INSTR_ASM_RANGE_CHECK_EN
    localparam bit RangeCheckEn = 1'b1;
`else
    localparam bit RangeCheckEn = 1'b0;
`endif

    logic [11:0] imm12;
    logic [1:0]  fmt;
    logic        sign_ok;

    assign imm12      = imm_i[11:0];
    assign fmt        = opcode_i[6:5];
    // In range when every bit above imm[10] is a copy of the sign bit.
    assign sign_ok    = (&imm_i[63:11]) || !(|imm_i[63:11]);
    assign range_ok_o = !RangeCheckEn || sign_ok;
    assign fmt_ok_o   = (fmt != FMT_ILLEGAL);

    always_comb begin
        word_o = '0;
        case (fmt)
            FMT_I:   word_o = {imm12, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S:   word_o = {imm12[11:5], rs2_i, rs1_i, funct3_i, imm12[4:0], opcode_i};
            FMT_SB:  word_o = {imm12[11], imm12[9:4], rs2_i, rs1_i, funct3_i,
                               imm12[3:0], imm12[10], opcode_i};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_asm_writer.sv
// Streams packed instruction words into instruction memory, one word per accepted beat.
// Range checking of immediates is compiled in with INSTR_ASM_RANGE_CHECK_EN (see imm_pack).
module instr_asm_writer
    import riscv_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [63:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              full,
    output logic              err
);

    localparam int                IDX_W = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    wr_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0]       word;
    logic              fmt_ok;
    logic              range_ok;
    logic              fire;

    imm_pack u_imm_pack (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .imm_i      (imm),
        .word_o     (word),
        .fmt_ok_o   (fmt_ok),
        .range_ok_o (range_ok)
    );

    assign in_ready = (state_q == ST_RUN) && !start;
    assign fire     = in_valid && in_ready;

    // start overrides everything, including a beat offered in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        err_d   = err_q;
        if (start) begin
            state_d = ST_RUN;
            idx_d   = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else if (fire) begin
            if (fmt_ok && range_ok) begin
                we_d    = 1'b1;
                addr_d  = BASE + {idx_q, 2'b00};
                wdata_d = word;
                idx_d   = idx_q + 1'b1;
                if (&idx_q) begin
                    full_d  = 1'b1;
                    state_d = ST_FULL;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_asm_writer.sv
// Bench for instr_asm_writer: directed encodings, reject, fill and reset cases, then random beats
// checked every cycle against a transaction-level model (honours INSTR_ASM_RANGE_CHECK_EN).
module tb_instr_asm_writer;
    import riscv_isa_pkg::*;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 2 ** (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6:0]        opcode = '0;
    logic [2:0]        funct3 = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [63:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              full;
    logic              err;

    int checks = 0;
    int errors = 0;

    instr_asm_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    // Instruction word built from the field positions by arithmetic on the 12-bit immediate.
    function automatic logic [31:0] encode(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] rdv, input logic [4:0] r1,
                                           input logic [4:0] r2, input logic [63:0] iv);
        int unsigned i12, o, f, d, a, b, w;
        i12 = int'(iv[11:0]); o = int'(op); f = int'(f3); d = int'(rdv); a = int'(r1); b = int'(r2);
        if (op[6:5] == 2'b00)
            w = (i12 << 20) + (a << 15) + (f << 12) + (d << 7) + o;
        else if (op[6:5] == 2'b01)
            w = ((i12 / 32) << 25) + (b << 20) + (a << 15) + (f << 12) + ((i12 % 32) << 7) + o;
        else
            w = ((i12 / 2048) << 31) + (((i12 / 16) % 64) << 25) + (b << 20) + (a << 15)
              + (f << 12) + ((i12 % 16) << 8) + (((i12 / 1024) % 2) << 7) + o;
        return w;
    endfunction

    // Decode-stage immediate generator: recovers the signed immediate from a word.
    function automatic int decodeImm(input logic [31:0] w);
        logic [11:0] f;
        if (w[6:5] == 2'b00)      f = w[31:20];
        else if (w[6:5] == 2'b01) f = {w[31:25], w[11:7]};
        else                      f = {w[31], w[7], w[30:25], w[11:8]};
        return {{20{f[11]}}, f};
    endfunction

    function automatic bit beatLegal(input logic [6:0] op, input logic [63:0] iv);
        bit ok;
        ok = (op[6:5] != 2'b10);
`ifdef INSTR_ASM_RANGE_CHECK_EN
        ok = ok && ($signed(iv) >= -64'sd2048) && ($signed(iv) <= 64'sd2047);
`endif
        return ok;
    endfunction

    // Transaction-level model: slot counter, running flag, sticky error, last write.
    bit                m_run, m_err, m_full, m_we;
    int                m_cnt;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    int                m_immval;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_err = 0; m_full = 0; m_we = 0; m_cnt = 0;
            m_addr = '0; m_wdata = '0;
        end else begin
            m_we = 0;
            if (start) begin
                m_run = 1; m_cnt = 0; m_err = 0; m_full = 0;
            end else if (in_valid && m_run) begin
                if (beatLegal(opcode, imm)) begin
                    m_we     = 1;
                    m_addr   = ADDR_W'((BASE_ADDR + 4 * m_cnt) % (1 << ADDR_W));
                    m_wdata  = encode(opcode, funct3, rd, rs1, rs2, imm);
                    m_immval = {{20{imm[11]}}, imm[11:0]};
                    m_cnt++;
                    if (m_cnt == DEPTH) begin
                        m_full = 1; m_run = 0;
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("cmp_in_ready", 64'(in_ready), 64'(m_run && !start));
        checkOutput("cmp_mem_we", 64'(mem_we), 64'(m_we));
        checkOutput("cmp_full", 64'(full), 64'(m_full));
        checkOutput("cmp_err", 64'(err), 64'(m_err));
        if (m_we) begin
            checkOutput("cmp_mem_addr", 64'(mem_addr), 64'(m_addr));
            checkOutput("cmp_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            checkOutput("cmp_roundtrip", 64'(decodeImm(mem_wdata)), 64'(m_immval));
        end
    end

    task automatic applyStimulus(input logic v, input logic s, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [4:0] rdv,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [63:0] iv);
        @(negedge clk);
        #1;
        in_valid = v; start = s; opcode = op; funct3 = f3;
        rd = rdv; rs1 = r1; rs2 = r2; imm = iv;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    endtask

    logic [6:0]  rop;
    logic [63:0] rimm;
    int          v;
    logic [1:0]  fsel;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        reset = 1'b1;
        idleCycle();
        checkOutput("idle_in_ready", 64'(in_ready), 64'd0);

        // T1..T4 directed encodings and rejects
        applyStimulus(1'b0, 1'b1, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd3, 5'd5, 5'd2, 5'd0, -64'sd8);
        applyStimulus(1'b1, 1'b0, OP_STORE, 3'd3, 5'd0, 5'd4, 5'd3, 64'd16);
        checkOutput("t1_we", 64'(mem_we), 64'd1);
        checkOutput("t1_addr", 64'(mem_addr), 64'h00);
        checkOutput("t1_wdata", 64'(mem_wdata), 64'hFF813283);
        applyStimulus(1'b1, 1'b0, OP_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 64'd6);
        checkOutput("t2_addr", 64'(mem_addr), 64'h04);
        checkOutput("t2_wdata", 64'(mem_wdata), 64'h00323823);
        applyStimulus(1'b1, 1'b0, 7'b1000011, 3'd0, 5'd1, 5'd1, 5'd1, 64'd1);
        checkOutput("t3_addr", 64'(mem_addr), 64'h08);
        checkOutput("t3_wdata", 64'(mem_wdata), 64'h00208663);
        checkOutput("t3_decode", 64'(decodeImm(mem_wdata)), 64'd6);
        applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd0, 5'd1, 5'd1, 5'd0, 64'd2048);
        checkOutput("t4_illegal_we", 64'(mem_we), 64'd0);
        checkOutput("t4_illegal_err", 64'(err), 64'd1);
        idleCycle();
`ifdef INSTR_ASM_RANGE_CHECK_EN
        checkOutput("t4_range_we", 64'(mem_we), 64'd0);
        checkOutput("t4_range_err", 64'(err), 64'd1);
        checkOutput("t4_range_full", 64'(full), 64'd0);
`else
        checkOutput("t4_trunc_we", 64'(mem_we), 64'd1);
        checkOutput("t4_trunc_addr", 64'(mem_addr), 64'h0C);
        checkOutput("t4_trunc_imm", 64'(mem_wdata[31:20]), 64'h800);
        checkOutput("t4_trunc_full", 64'(full), 64'd1);
`endif

        // T5 fill, held beat, restart
        applyStimulus(1'b0, 1'b1, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        checkOutput("t5_start_err_pending", 64'(err), 64'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, OP_LOAD, 3'(k), 5'(k + 1), 5'(k), 5'd0, 64'(k));
            if (k > 0) checkOutput("t5_fill_addr", 64'(mem_addr), 64'(4 * (k - 1)));
        end
        applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd7, 5'd9, 5'd9, 5'd0, 64'd99);
        checkOutput("t5_last_addr", 64'(mem_addr), 64'h0C);
        checkOutput("t5_full", 64'(full), 64'd1);
        checkOutput("t5_ready_low", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd7, 5'd9, 5'd9, 5'd0, 64'd99);
        checkOutput("t5_held_we", 64'(mem_we), 64'd0);
        applyStimulus(1'b1, 1'b1, OP_LOAD, 3'd7, 5'd9, 5'd9, 5'd0, 64'd99);
        applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd7, 5'd9, 5'd9, 5'd0, 64'd99);
        checkOutput("t5_restart_full", 64'(full), 64'd0);
        checkOutput("t5_start_beat_dropped", 64'(mem_we), 64'd0);
        applyStimulus(1'b1, 1'b0, OP_STORE, 3'd2, 5'd0, 5'd3, 5'd4, 64'd5);
        checkOutput("t5_restart_we", 64'(mem_we), 64'd1);
        checkOutput("t5_restart_addr", 64'(mem_addr), 64'h00);

        // T6 async reset while a write is on the port
        @(negedge clk);
        checkOutput("t6_we_before", 64'(mem_we), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t6_we", 64'(mem_we), 64'd0);
        checkOutput("t6_addr", 64'(mem_addr), 64'd0);
        checkOutput("t6_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("t6_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd1, 5'd1, 5'd1, 5'd0, 64'd1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, OP_LOAD, 3'd1, 5'd1, 5'd1, 5'd0, 64'd1);
            checkOutput("t6_ready_after", 64'(in_ready), 64'd0);
            checkOutput("t6_no_write", 64'(mem_we), 64'd0);
        end

        // Random beats, compared every cycle by the model process
        for (int n = 0; n < 600; n++) begin
            fsel = 2'($urandom_range(0, 2));
            if (fsel == 2'd2) fsel = 2'b11;
            if ($urandom_range(0, 11) == 0) fsel = 2'b10;
            rop = {fsel, 5'($urandom)};
            case ($urandom_range(0, 9))
                0:       rimm = {$urandom, $urandom};
                1:       begin
                             case ($urandom_range(0, 3))
                                 0: v = 2047;
                                 1: v = -2048;
                                 2: v = 2048;
                                 default: v = -2049;
                             endcase
                             rimm = {{32{v[31]}}, v};
                         end
                default: begin
                             v = int'($urandom_range(0, 4095)) - 2048;
                             rimm = {{32{v[31]}}, v};
                         end
            endcase
            applyStimulus(1'($urandom_range(0, 9) < 7),
                          1'((!m_run && $urandom_range(0, 2) == 0) || $urandom_range(0, 39) == 0),
                          rop, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm);
        end
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
